// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: shared types, TAP sequencing constants and the IDCODE sanity check
package jtag_host_pkg;
   typedef enum logic [2:0] {IDLE, RESET_TAP, GOTO_SHIFT, SHIFT, EXIT, DONE} state_t;
   localparam int IDCODE_WIDTH = 32;
   localparam int TLR_TCKS = 5;
   localparam int SHIFT_ENTRY_TCKS = 4;
   localparam int EXIT_TCKS = 2;
   // Run-Test/Idle, Select-DR, Capture-DR, Shift-DR; bit 0 goes out first
   localparam logic [3:0] SHIFT_ENTRY_TMS = 4'b0010;
   // Update-DR then Run-Test/Idle; bit 0 goes out first
   localparam logic [1:0] EXIT_TMS = 2'b01;
   // a real IDCODE always has bit 0 set; all ones means TDO is floating high
   function automatic logic idcode_bad(input logic [IDCODE_WIDTH-1:0] id);
      return !id[0] || (id == '1);
   endfunction
endpackage

// File: rtl/jtag_idcode_reader_if.sv
// jtag_idcode_reader_if: request/result handshake plus the four JTAG pins of the reader
interface jtag_idcode_reader_if;
   logic start;
   logic busy;
   logic done;
   logic [jtag_host_pkg::IDCODE_WIDTH-1:0] idcode;
   logic id_valid;
   logic id_error;
   logic tck_out;
   logic tms_out;
   logic tdi_out;
   logic tdo_in;
   modport master (
      output start, tdo_in,
      input busy, done, idcode, id_valid, id_error, tck_out, tms_out, tdi_out
   );
   modport slave (
      input start, tdo_in,
      output busy, done, idcode, id_valid, id_error, tck_out, tms_out, tdi_out
   );
endinterface

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK with a low phase first, TCK_DIV clk per half-period, plus rise/fall strobes
module jtag_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tck,
   output logic tck_rise,
   output logic tck_fall
);
   localparam logic [7:0] LAST = 8'(TCK_DIV - 1);
   logic [7:0] phase;
   logic wrap;
   assign wrap = en && (phase == LAST);
   assign tck_rise = wrap && !tck;
   assign tck_fall = wrap && tck;
   // half-period counter; TCK parks low whenever the generator is disabled
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         phase <= '0;
         tck <= 1'b0;
      end else if (wrap) begin
         phase <= '0;
         tck <= !tck;
      end else begin
         phase <= phase + 8'd1;
      end
   end
endmodule

// File: rtl/jtag_idcode_reader.sv
// jtag_idcode_reader: resets the TAP, walks to Shift-DR and captures the 32-bit IDCODE;
// defining IDCODE_CHECK_EN adds a sanity check reported on id_error
module jtag_idcode_reader
   import jtag_host_pkg::*;
#(
   parameter int TCK_DIV = 2
) (
   input logic clk,
   input logic reset,
   jtag_idcode_reader_if.slave bus
);
   state_t state, state_nx;
   logic [5:0] bit_cnt, bit_cnt_nx, cnt_inc, last_cnt;
   logic tms_nx, tck_rise, tck_fall, last, accept, finish;
   logic [IDCODE_WIDTH-1:0] shift_q;

   jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
      .clk(clk),
      .reset(reset),
      .en(bus.busy),
      .tck(bus.tck_out),
      .tck_rise(tck_rise),
      .tck_fall(tck_fall)
   );

   assign bus.tdi_out = 1'b1;
   assign bus.busy = (state != IDLE) && (state != DONE);
   assign cnt_inc = bit_cnt + 6'd1;
   assign last_cnt = state == RESET_TAP  ? 6'(TLR_TCKS - 1) :
                     state == GOTO_SHIFT ? 6'(SHIFT_ENTRY_TCKS - 1) :
                     state == SHIFT      ? 6'(IDCODE_WIDTH - 1) : 6'(EXIT_TCKS - 1);
   assign last = bit_cnt == last_cnt;
   assign accept = (state == IDLE) && bus.start;
   assign finish = (state == EXIT) && tck_fall && last;

   // next state, TCK count within the phase, and the TMS level for the upcoming TCK
   always_comb begin
      state_nx = state;
      bit_cnt_nx = bit_cnt;
      tms_nx = bus.tms_out;
      if (accept) begin
         state_nx = RESET_TAP;
         tms_nx = 1'b1;
      end else if (state == DONE) begin
         state_nx = IDLE;
      end else if (tck_fall) begin
         bit_cnt_nx = last ? 6'd0 : cnt_inc;
         case (state)
            RESET_TAP: begin
               state_nx = last ? GOTO_SHIFT : state;
               tms_nx = last ? SHIFT_ENTRY_TMS[0] : 1'b1;
            end
            GOTO_SHIFT: begin
               state_nx = last ? SHIFT : state;
               tms_nx = last ? 1'b0 : SHIFT_ENTRY_TMS[cnt_inc[1:0]];
            end
            SHIFT: begin
               state_nx = last ? EXIT : state;
               tms_nx = last ? EXIT_TMS[0] : (cnt_inc == last_cnt);
            end
            EXIT: begin
               state_nx = last ? DONE : state;
               tms_nx = last ? bus.tms_out : EXIT_TMS[cnt_inc[0]];
            end
            default: ;
         endcase
      end
   end

   // FSM state, TCK counter and TMS registers; TMS idles high out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         bit_cnt <= '0;
         bus.tms_out <= 1'b1;
      end else begin
         state <= state_nx;
         bit_cnt <= bit_cnt_nx;
         bus.tms_out <= tms_nx;
      end
   end

   // TDO is stable since the previous falling TCK, so take it as TCK rises; LSB arrives first
   always_ff @(posedge clk) begin
      if (reset)
         shift_q <= '0;
      else if (state == SHIFT && tck_rise)
         shift_q <= {bus.tdo_in, shift_q[IDCODE_WIDTH-1:1]};
   end

   // result registers load on entry to DONE so they are visible together with the done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.done <= 1'b0;
         bus.idcode <= '0;
         bus.id_valid <= 1'b0;
      end else begin
         bus.done <= finish;
         if (accept)
            bus.id_valid <= 1'b0;
         if (finish) begin
            bus.idcode <= shift_q;
            bus.id_valid <= 1'b1;
         end
      end
   end

`ifdef IDCODE_CHECK_EN
   // flag a missing device or a value that cannot be a legal IDCODE
   always_ff @(posedge clk) begin
      if (reset || accept)
         bus.id_error <= 1'b0;
      else if (finish)
         bus.id_error <= idcode_bad(shift_q);
   end
`else
   assign bus.id_error = 1'b0;
`endif
endmodule

// File: tb/tb_jtag_idcode_reader.sv
// tb_jtag_idcode_reader: table-driven reads against a behavioural TAP, TCK_DIV=2 and TCK_DIV=1
module tb_jtag_idcode_reader;
`ifdef IDCODE_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   typedef struct {
      logic div1;
      logic [31:0] tap_id;
      logic stuck;
      logic [31:0] exp_id;
      logic exp_err_chk;
      int exp_cyc;
   } vec_t;

   typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, UPDR, SELIR, LOST} tap_t;

   logic clk = 1'b0;
   logic reset;
   logic sel;
   logic stuck;
   logic [31:0] tap_id;
   logic [31:0] tap_dr = '0;
   tap_t tap_st = TLR;
   logic tap_tdo = 1'b1;
   logic tap_tck, tap_tms;
   logic tms_log [256];
   logic [7:0] n_tck = '0;
   logic [31:0] last_id [2];
   int n_vec = 0;
   int n_err = 0;
   int tck_viol = 0;
   logic m_done, m_busy, m_valid, m_err;
   logic [31:0] m_idcode;
   vec_t vt [6];

   always #5 clk = !clk;

   jtag_idcode_reader_if ifa ();
   jtag_idcode_reader_if ifb ();

   jtag_idcode_reader #(.TCK_DIV(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   jtag_idcode_reader #(.TCK_DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

   assign tap_tck = sel ? ifb.tck_out : ifa.tck_out;
   assign tap_tms = sel ? ifb.tms_out : ifa.tms_out;
   assign ifa.tdo_in = tap_tdo;
   assign ifb.tdo_in = tap_tdo;
   assign m_done = sel ? ifb.done : ifa.done;
   assign m_busy = sel ? ifb.busy : ifa.busy;
   assign m_valid = sel ? ifb.id_valid : ifa.id_valid;
   assign m_err = sel ? ifb.id_error : ifa.id_error;
   assign m_idcode = sel ? ifb.idcode : ifa.idcode;

   // behavioural TAP: DR path state machine, logs TMS per TCK
   always @(posedge tap_tck) begin
      tms_log[n_tck] <= tap_tms;
      n_tck <= n_tck + 8'd1;
      case (tap_st)
         TLR: tap_st <= tap_tms ? TLR : RTI;
         RTI: tap_st <= tap_tms ? SELDR : RTI;
         SELDR: tap_st <= tap_tms ? SELIR : CAPDR;
         CAPDR: begin
            tap_dr <= tap_id;
            tap_st <= tap_tms ? EX1DR : SHDR;
         end
         SHDR: begin
            tap_dr <= {1'b1, tap_dr[31:1]};
            tap_st <= tap_tms ? EX1DR : SHDR;
         end
         EX1DR: tap_st <= tap_tms ? UPDR : LOST;
         UPDR: tap_st <= tap_tms ? SELDR : RTI;
         SELIR: tap_st <= tap_tms ? TLR : LOST;
         default: tap_st <= LOST;
      endcase
   end

   // TDO changes on the falling TCK
   always @(negedge tap_tck)
      tap_tdo <= stuck ? 1'b1 : (tap_st == SHDR ? tap_dr[0] : 1'b1);

   // TCK must stay low whenever the reader is not busy
   always @(negedge clk) begin
      if (!ifa.busy && ifa.tck_out) tck_viol++;
      if (!ifb.busy && ifb.tck_out) tck_viol++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel) ifb.start = v;
      else ifa.start = v;
   endtask

   function automatic logic [63:0] exp_tms();
      logic [63:0] e;
      e = '0;
      for (int i = 0; i < 5; i++) e[i] = 1'b1;
      e[6] = 1'b1;
      e[40] = 1'b1;
      e[41] = 1'b1;
      return e;
   endfunction

   // one read from the IDLE state; cyc is clk count from acceptance to done (0 = timeout)
   task automatic do_read(input int repulse, output int cyc);
      logic [7:0] base;
      logic [63:0] got;
      base = n_tck;
      check("idle_before_start", 64'(m_busy), 64'd0);
      drive_start(1'b1);
      @(posedge clk);
      #1;
      drive_start(1'b0);
      check("busy_after_accept", 64'(m_busy), 64'd1);
      check("valid_cleared", 64'(m_valid), 64'd0);
      check("err_cleared", 64'(m_err), 64'd0);
      check("idcode_held", 64'(m_idcode), 64'(last_id[sel]));
      cyc = 0;
      for (int n = 1; n <= 400 && cyc == 0; n++) begin
         drive_start(n == repulse);
         @(posedge clk);
         #1;
         if (m_done) cyc = n;
      end
      drive_start(1'b0);
      got = '0;
      for (int i = 0; i < 43; i++) got[i] = tms_log[8'(base + 8'(i))];
      check("tck_count", 64'(8'(n_tck - base)), 64'd43);
      check("tms_trace", got, exp_tms());
      check("tap_in_rti", 64'(int'(tap_st)), 64'(int'(RTI)));
      check("busy_at_done", 64'(m_busy), 64'd0);
      drive_start(1'b1);
      @(posedge clk);
      #1;
      drive_start(1'b0);
      check("done_one_pulse", 64'(m_done), 64'd0);
      check("start_in_done_ignored", 64'(m_busy), 64'd0);
   endtask

   task automatic check_result(input string tag, input int cyc, input int exp_cyc,
                               input logic [31:0] exp_id, input logic exp_err);
      check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
      check({tag, "_idcode"}, 64'(m_idcode), 64'(exp_id));
      check({tag, "_id_valid"}, 64'(m_valid), 64'd1);
      check({tag, "_id_error"}, 64'(m_err), 64'(exp_err));
      last_id[sel] = exp_id;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tck"}, 64'(ifa.tck_out), 64'd0);
      check({tag, "_tms"}, 64'(ifa.tms_out), 64'd1);
      check({tag, "_tdi"}, 64'(ifa.tdi_out), 64'd1);
      check({tag, "_busy"}, 64'(ifa.busy), 64'd0);
      check({tag, "_done"}, 64'(ifa.done), 64'd0);
      check({tag, "_idcode"}, 64'(ifa.idcode), 64'd0);
      check({tag, "_id_valid"}, 64'(ifa.id_valid), 64'd0);
      check({tag, "_id_error"}, 64'(ifa.id_error), 64'd0);
      check({tag, "_b_busy"}, 64'(ifb.busy), 64'd0);
      check({tag, "_b_tms"}, 64'(ifb.tms_out), 64'd1);
   endtask

   initial begin
      int cyc;
      vt[0] = '{1'b0, 32'h4BA00477, 1'b0, 32'h4BA00477, 1'b0, 172};
      vt[1] = '{1'b0, 32'h4BA00476, 1'b0, 32'h4BA00476, 1'b1, 172};
      vt[2] = '{1'b0, 32'h4BA00477, 1'b1, 32'hFFFFFFFF, 1'b1, 172};
      vt[3] = '{1'b1, 32'h4BA00477, 1'b0, 32'h4BA00477, 1'b0, 86};
      vt[4] = '{1'b0, 32'h12345679, 1'b0, 32'h12345679, 1'b0, 172};
      vt[5] = '{1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 86};
      reset = 1'b1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      sel = 1'b0;
      stuck = 1'b0;
      tap_id = '0;
      last_id[0] = '0;
      last_id[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 6; v++) begin
         sel = vt[v].div1;
         tap_id = vt[v].tap_id;
         stuck = vt[v].stuck;
         do_read(0, cyc);
         check_result($sformatf("vec%0d", v), cyc, vt[v].exp_cyc, vt[v].exp_id, vt[v].exp_err_chk & CHK);
         stuck = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end

      sel = 1'b0;
      tap_id = 32'h4BA00477;
      do_read(50, cyc);
      check_result("repulse", cyc, 172, 32'h4BA00477, 1'b0);
      repeat (200) begin
         @(posedge clk);
         #1;
         if (m_done || m_busy) break;
      end
      check("no_queued_read", 64'(m_busy), 64'd0);
      tap_id = 32'h0A0B0C0D;
      do_read(0, cyc);
      check_result("second_read", cyc, 172, 32'h0A0B0C0D, 1'b0);

      tap_id = 32'h4BA00477;
      drive_start(1'b1);
      @(posedge clk);
      #1;
      drive_start(1'b0);
      repeat (99) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("midreset");
      reset = 1'b0;
      last_id[0] = '0;
      last_id[1] = '0;
      @(posedge clk);
      #1;
      do_read(0, cyc);
      check_result("after_reset", cyc, 172, 32'h4BA00477, 1'b0);

      check("tck_low_when_idle", 64'(tck_viol), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/jtag_idcode_reader.md
JTAG_IDCODE_READER -- requirements
Module: jtag_idcode_reader

Interface
REQ-001 Parameter TCK_DIV, default 2, clk cycles per TCK half-period; legal range is 1 to 255.
REQ-002 Port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 Port reset  input  1  reset, synchronous and active-high.
REQ-004 Port start  input  1  request one IDCODE read; sampled only while busy=0.
REQ-005 Port tdo_in  input  1  TDO of the target TAP.
REQ-006 Port tck_out  output  1  generated TCK to the target.
REQ-007 Port tms_out  output  1  TMS to the target.
REQ-008 Port tdi_out  output  1  TDI to the target; tied to 1 (ones fill the chain).
REQ-009 Port busy  output  1  high from the clk after start is accepted until done.
REQ-010 Port done  output  1  one-clk pulse when a read completes.
REQ-011 Port idcode  output  32  last captured identification code.
REQ-012 Port id_valid  output  1  idcode holds the result of a completed read.
REQ-013 Port id_error  output  1  completed read failed the IDCODE sanity check.

Function
REQ-014 TCK period shall be 2*TCK_DIV clk cycles: low phase first, then high phase; tck_out is low whenever busy=0.
REQ-015 tms_out shall change only in the clk where tck_out falls, or in the clk where start is accepted.
REQ-016 FSM states shall be IDLE, RESET_TAP, GOTO_SHIFT, SHIFT, EXIT, DONE.
REQ-017 IDLE -> RESET_TAP on start=1.
REQ-018 RESET_TAP shall issue 5 TCK with TMS=1, placing the target in Test-Logic-Reset; IDCODE is selected by default.
REQ-019 GOTO_SHIFT shall issue 4 TCK with TMS=0,1,0,0 (Run-Test/Idle, Select-DR, Capture-DR, Shift-DR).
REQ-020 SHIFT shall issue 32 TCK with TMS=0, except TMS=1 on the 32nd (to Exit1-DR).
REQ-021 In SHIFT, tdo_in shall be sampled in the clk where tck_out rises, with idcode_shift <= {tdo_in, idcode_shift[31:1]}; the first bit sampled is bit 0.
REQ-022 EXIT shall issue 2 TCK with TMS=1,0 (Update-DR, Run-Test/Idle).
REQ-023 DONE shall last one clk; it pulses done, loads idcode, sets id_valid, updates id_error, clears busy, and returns to IDLE.
REQ-024 The total sequence is 43 TCK; done shall assert exactly 86*TCK_DIV clk after the clk in which start is accepted.
REQ-025 start while busy=1 or in DONE shall be ignored and not queued.
REQ-026 On start acceptance, id_valid and id_error shall clear; idcode shall hold its old value until DONE.
REQ-027 The TCK phase counter shall wrap at TCK_DIV-1, and the bit counter shall be 6 bits wide, counting 0..31.

Reset
REQ-028 reset=1 shall force, on the next clk edge: state=IDLE, tck_out=0, tms_out=1, tdi_out=1, busy=0, done=0, idcode=0, id_valid=0, id_error=0, and all counters to 0.
REQ-029 reset shall take priority over start and over any in-progress sequence; no partial result is kept.

Configuration
REQ-030 Macro IDCODE_CHECK_EN defined: at DONE, id_error=1 if captured bit0=0 or the value is 32'hFFFFFFFF (no device); id_valid is still set.
REQ-031 Macro IDCODE_CHECK_EN undefined: id_error shall be constant 0 and no check logic is built.

Structure
REQ-032 Package jtag_host_pkg shall hold the FSM state enum, IDCODE_WIDTH=32, TLR_TCKS=5, SHIFT_ENTRY_TMS=4'b0010 (LSB first), and EXIT_TMS.
REQ-033 Sub-module jtag_tck_gen shall produce tck_out plus one-clk tck_rise/tck_fall strobes from TCK_DIV and an enable; the FSM advances only on these strobes.

Verification
REQ-034 TCK_DIV=2, behavioural TAP with IDCODE 32'h4BA00477, start pulse -> TMS per TCK: 1x5, 0,1,0,0, 0x31, 1, 1, 0; done at clk 172; idcode=32'h4BA00477, id_valid=1, id_error=0.
REQ-035 TAP IDCODE 32'h4BA00476 -> idcode=32'h4BA00476, id_error=1 with IDCODE_CHECK_EN and 0 without.
REQ-036 tdo_in stuck at 1 -> idcode=32'hFFFFFFFF, id_error=1 with IDCODE_CHECK_EN.
REQ-037 start re-pulsed at clk 50 of a read -> ignored, a single done at clk 172; a start after done clears id_valid at acceptance, and a second done follows 172 clk later.
REQ-038 reset at clk 100 (in SHIFT) -> next clk matches all REQ-028 values; a following start completes normally with the correct idcode.
REQ-039 TCK_DIV=1 -> TCK period 2 clk, done at clk 86, same idcode as REQ-034.
